// File: rtl/cmp_mag_seq.sv
// Multi-cycle W-bit magnitude comparator scanning CHUNK bits per cycle from the MSB,
// stopping at the first differing chunk. Signed operands are enabled by CMP_MAG_SEQ_SIGNED_EN.
module cmp_mag_seq #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    input  logic         signed_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         result,
    output logic         gt,
    output logic         eq
);

    localparam int NCH  = W / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > W) || ((W % CHUNK) != 0)) begin : g_bad_cfg
            $error("cmp_mag_seq: CHUNK must divide W and satisfy 1 <= CHUNK <= W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            gt_q, gt_d, eq_q, eq_d, result_q, result_d;

    logic [W-1:0]     a_cmp, b_cmp;
    logic [CHUNK-1:0] a_ch [NCH];
    logic [CHUNK-1:0] b_ch [NCH];
    logic [CHUNK-1:0] a_cur, b_cur;

    function automatic logic op_result(input logic [1:0] sel, input logic g, input logic e);
        logic r;
        case (sel)
            2'b00:   r = g | e;
            2'b01:   r = g;
            2'b10:   r = e;
            2'b11:   r = ~g;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef CMP_MAG_SEQ_SIGNED_EN
    localparam logic [W-1:0] MSB_MASK = W'(1) << (W - 1);
    logic sm_q, sm_d;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        if (sm_q) begin
            a_cmp = a_q ^ MSB_MASK;
            b_cmp = b_q ^ MSB_MASK;
        end else begin
            a_cmp = a_q;
            b_cmp = b_q;
        end
    end
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;

    // Unsigned-only build: operands are compared as latched.
    always_comb begin
        a_cmp = a_q;
        b_cmp = b_q;
    end
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chunk
        assign a_ch[i] = a_cmp[W-1-i*CHUNK -: CHUNK];
        assign b_ch[i] = b_cmp[W-1-i*CHUNK -: CHUNK];
    end

    assign a_cur = a_ch[idx_q];
    assign b_cur = b_ch[idx_q];

    // Next-state, operand capture and result computation.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        result_d = result_q;
`ifdef CMP_MAG_SEQ_SIGNED_EN
        sm_d     = sm_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
`ifdef CMP_MAG_SEQ_SIGNED_EN
                    sm_d    = signed_mode;
`endif
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (a_cur != b_cur) begin
                    gt_d     = (a_cur > b_cur);
                    eq_d     = 1'b0;
                    result_d = op_result(op_q, a_cur > b_cur, 1'b0);
                    state_d  = ST_DONE;
                end else if (idx_q == LAST_IDX) begin
                    gt_d     = 1'b0;
                    eq_d     = 1'b1;
                    result_d = op_result(op_q, 1'b0, 1'b1);
                    state_d  = ST_DONE;
                end else begin
                    idx_d    = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            idx_q    <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            result_q <= 1'b0;
`ifdef CMP_MAG_SEQ_SIGNED_EN
            sm_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            result_q <= result_d;
`ifdef CMP_MAG_SEQ_SIGNED_EN
            sm_q     <= sm_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign gt        = gt_q;
    assign eq        = eq_q;

endmodule
